// File: rtl/s4_pkg.sv
// Shared widths, group flag codes and release record for the last arithmetic-encoder stage.
package s4_pkg;

    localparam int unsigned S4_RANGE_WIDTH      = 16;
    localparam int unsigned S4_LOW_WIDTH        = 24;
    localparam int unsigned S4_SYMBOL_WIDTH     = 4;
    localparam int unsigned S4_LUT_ADDR_WIDTH   = 8;
    localparam int unsigned S4_LUT_DATA_WIDTH   = 16;
    localparam int unsigned S4_BITSTREAM_WIDTH  = 8;
    localparam int unsigned S4_D_SIZE           = 5;
    localparam int unsigned S4_ADDR_CARRY_WIDTH = 4;

    typedef enum logic [2:0] {
        GrpNone  = 3'd0,
        GrpLit1  = 3'd1,
        GrpLit2  = 3'd2,
        GrpLit3  = 3'd3,
        GrpLit4  = 3'd4,
        GrpRun   = 3'd5,
        GrpRunT1 = 3'd6,
        GrpRunT2 = 3'd7
    } grp_flag_e;

    typedef enum logic [1:0] {
        InNone    = 2'd0,
        InA       = 2'd1,
        InAB      = 2'd2,
        InIllegal = 2'd3
    } in_flag_e;

    // One literal byte optionally followed by run_cnt copies of run_byte.
    typedef struct packed {
        logic                           lit_valid;
        logic [S4_BITSTREAM_WIDTH-1:0]  lit;
        logic [S4_BITSTREAM_WIDTH-1:0]  run_byte;
        logic [S4_ADDR_CARRY_WIDTH-1:0] run_cnt;
    } release_t;

endpackage

// File: rtl/s4_carry_step.sv
// Combinational update of the held byte / pending 0xFF run for one incoming nine-bit byte.
module s4_carry_step
    import s4_pkg::*;
(
    input  logic                           en_i,
    input  logic [S4_BITSTREAM_WIDTH:0]    byte_i,
    input  logic [S4_BITSTREAM_WIDTH-1:0]  prev_i,
    input  logic                           prev_valid_i,
    input  logic [S4_ADDR_CARRY_WIDTH-1:0] run_i,
    output logic [S4_BITSTREAM_WIDTH-1:0]  prev_o,
    output logic                           prev_valid_o,
    output logic [S4_ADDR_CARRY_WIDTH-1:0] run_o,
    output release_t                       rel_o
);

    logic                          carry;
    logic [S4_BITSTREAM_WIDTH-1:0] value;

    assign carry = byte_i[S4_BITSTREAM_WIDTH];
    assign value = byte_i[S4_BITSTREAM_WIDTH-1:0];

    always_comb begin
        prev_o       = prev_i;
        prev_valid_o = prev_valid_i;
        run_o        = run_i;
        rel_o        = '0;
        if (en_i) begin
            if (!prev_valid_i) begin
                // First byte of the stream has nothing to carry into.
                prev_o       = value;
                prev_valid_o = 1'b1;
            end else if (!carry && (value == '1)) begin
                run_o = run_i + 1'b1;
            end else begin
                rel_o.lit_valid = 1'b1;
                rel_o.lit       = prev_i + {{(S4_BITSTREAM_WIDTH-1){1'b0}}, carry};
                rel_o.run_byte  = carry ? '0 : '1;
                rel_o.run_cnt   = run_i;
                prev_o          = value;
                run_o           = '0;
            end
        end
    end

endmodule

// File: rtl/stage_4_carry_propagation.sv
// Final encoder stage: resolves carries into held bytes and emits one compact release group
// (literals plus at most one run) per cycle.
module stage_4_carry_propagation
    import s4_pkg::*;
(
    input  logic                          s4_clk,
    input  logic                          s4_reset,
    input  logic                          s4_flag_first,
    input  logic                          s4_final_flag,
    input  logic                          s4_final_flag_2_3,
    input  logic [S4_RANGE_WIDTH-1:0]     in_arith_bitstream_1,
    input  logic [S4_RANGE_WIDTH-1:0]     in_arith_bitstream_2,
    input  logic [S4_RANGE_WIDTH-1:0]     in_arith_range,
    input  logic [S4_LOW_WIDTH-1:0]       in_arith_low,
    input  logic [S4_D_SIZE-1:0]          in_arith_cnt,
    input  logic [1:0]                    in_arith_flag,
    output logic [S4_BITSTREAM_WIDTH-1:0] out_carry_bit_1,
    output logic [S4_BITSTREAM_WIDTH-1:0] out_carry_bit_2,
    output logic [S4_BITSTREAM_WIDTH-1:0] out_carry_bit_3,
    output logic [S4_BITSTREAM_WIDTH-1:0] out_carry_bit_4,
    output logic [S4_BITSTREAM_WIDTH-1:0] out_carry_bit_5,
    output logic [2:0]                    out_carry_flag_bitstream,
    output logic                          output_flag_last
);

    logic [S4_BITSTREAM_WIDTH-1:0]  prev_q, prev_d, prev_a, prev_b;
    logic                           prev_valid_q, prev_valid_d, prev_valid_a, prev_valid_b;
    logic [S4_ADDR_CARRY_WIDTH-1:0] run_q, run_d, run_a, run_b;
    logic                           pend_q, pend_d;
    release_t                       rel_a, rel_b, rel_f;
    in_flag_e                       in_flag;
    logic                           en_a, en_b, flush;

    logic [4:0][S4_BITSTREAM_WIDTH-1:0] slot, slot_q;
    logic [2:0]                         n_slot;
    logic                               have_run;
    grp_flag_e                          grp_flag, flag_q;
    logic                               last_q;
    release_t                           segs [3];

    logic unused_inputs;
    assign unused_inputs = ^{in_arith_range, in_arith_low, in_arith_cnt,
                             in_arith_bitstream_1[S4_RANGE_WIDTH-1:S4_BITSTREAM_WIDTH+1],
                             in_arith_bitstream_2[S4_RANGE_WIDTH-1:S4_BITSTREAM_WIDTH+1]};

    assign in_flag = in_flag_e'(in_arith_flag);
    assign en_a    = (in_flag == InA) || (in_flag == InAB);
    assign en_b    = (in_flag == InAB);
    assign flush   = (s4_final_flag && !s4_final_flag_2_3) || pend_q;

    s4_carry_step u_step_a (
        .en_i         (en_a),
        .byte_i       (in_arith_bitstream_1[S4_BITSTREAM_WIDTH:0]),
        .prev_i       (prev_q),
        .prev_valid_i (prev_valid_q),
        .run_i        (run_q),
        .prev_o       (prev_a),
        .prev_valid_o (prev_valid_a),
        .run_o        (run_a),
        .rel_o        (rel_a)
    );

    s4_carry_step u_step_b (
        .en_i         (en_b),
        .byte_i       (in_arith_bitstream_2[S4_BITSTREAM_WIDTH:0]),
        .prev_i       (prev_a),
        .prev_valid_i (prev_valid_a),
        .run_i        (run_a),
        .prev_o       (prev_b),
        .prev_valid_o (prev_valid_b),
        .run_o        (run_b),
        .rel_o        (rel_b)
    );

    // Flush releases whatever is still held after this cycle's bytes.
    always_comb begin
        rel_f = '0;
        if (flush) begin
            rel_f.lit_valid = prev_valid_b;
            rel_f.lit       = prev_b;
            rel_f.run_byte  = '1;
            rel_f.run_cnt   = run_b;
        end
    end

    // Only a run directly preceded by exactly one literal can use the run encoding;
    // any other run (always length 1 in legal streams) is emitted as a literal.
    always_comb begin
        segs[0]  = rel_a;
        segs[1]  = rel_b;
        segs[2]  = rel_f;
        slot     = '0;
        n_slot   = '0;
        have_run = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (segs[s].lit_valid && (n_slot < (have_run ? 3'd5 : 3'd4))) begin
                slot[n_slot] = segs[s].lit;
                n_slot       = n_slot + 3'd1;
            end
            if (segs[s].run_cnt != '0) begin
                if (!have_run && (n_slot == 3'd1)) begin
                    slot[1]                          = segs[s].run_byte;
                    slot[2][S4_ADDR_CARRY_WIDTH-1:0] = segs[s].run_cnt;
                    n_slot                           = 3'd3;
                    have_run                         = 1'b1;
                end else if (n_slot < (have_run ? 3'd5 : 3'd4)) begin
                    slot[n_slot] = segs[s].run_byte;
                    n_slot       = n_slot + 3'd1;
                end
            end
        end
        grp_flag = have_run ? grp_flag_e'(n_slot + 3'd2) : grp_flag_e'(n_slot);
    end

    always_comb begin
        prev_d       = prev_b;
        prev_valid_d = prev_valid_b;
        run_d        = run_b;
        pend_d       = s4_final_flag && s4_final_flag_2_3 && !pend_q;
        if (flush) begin
            prev_d       = '0;
            prev_valid_d = 1'b0;
            run_d        = '0;
            pend_d       = 1'b0;
        end
    end

    always_ff @(posedge s4_clk or negedge s4_reset) begin
        if (!s4_reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            run_q        <= '0;
            pend_q       <= 1'b0;
            slot_q       <= '0;
            flag_q       <= GrpNone;
            last_q       <= 1'b0;
        end else if (s4_flag_first) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            run_q        <= '0;
            pend_q       <= 1'b0;
            slot_q       <= '0;
            flag_q       <= GrpNone;
            last_q       <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            run_q        <= run_d;
            pend_q       <= pend_d;
            slot_q       <= slot;
            flag_q       <= grp_flag;
            last_q       <= flush;
        end
    end

    assign out_carry_bit_1          = slot_q[0];
    assign out_carry_bit_2          = slot_q[1];
    assign out_carry_bit_3          = slot_q[2];
    assign out_carry_bit_4          = slot_q[3];
    assign out_carry_bit_5          = slot_q[4];
    assign out_carry_flag_bitstream = flag_q;
    assign output_flag_last         = last_q;

endmodule

// File: tb/tb_stage_4_carry_propagation.sv
// Bench for stage_4_carry_propagation: directed vector table, run-length boundary, and a
// randomized stream checked against a byte-queue ripple-carry model.
module tb_stage_4_carry_propagation;

    logic        clk;
    logic        rst_n;
    logic        flag_first, final_flag, final_2_3;
    logic [15:0] bs1, bs2, rng;
    logic [23:0] low;
    logic [4:0]  cnt;
    logic [1:0]  aflag;
    logic [7:0]  b1, b2, b3, b4, b5;
    logic [2:0]  oflag;
    logic        olast;

    int checks = 0;
    int errors = 0;

    stage_4_carry_propagation dut (
        .s4_clk                   (clk),
        .s4_reset                 (rst_n),
        .s4_flag_first            (flag_first),
        .s4_final_flag            (final_flag),
        .s4_final_flag_2_3        (final_2_3),
        .in_arith_bitstream_1     (bs1),
        .in_arith_bitstream_2     (bs2),
        .in_arith_range           (rng),
        .in_arith_low             (low),
        .in_arith_cnt             (cnt),
        .in_arith_flag            (aflag),
        .out_carry_bit_1          (b1),
        .out_carry_bit_2          (b2),
        .out_carry_bit_3          (b3),
        .out_carry_bit_4          (b4),
        .out_carry_bit_5          (b5),
        .out_carry_flag_bitstream (oflag),
        .output_flag_last         (olast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ff, fin, f23;
        logic [1:0] fl;
        logic [8:0] a, b;
        logic [2:0] ef;
        logic [7:0] e1, e2, e3, e4, e5;
        logic       el;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ff, logic fin, logic f23, logic [1:0] fl, logic [8:0] a,
                                logic [8:0] b, logic [2:0] ef, logic [7:0] e1, logic [7:0] e2,
                                logic [7:0] e3, logic [7:0] e4, logic [7:0] e5, logic el);
        vec_t v;
        v.ff = ff; v.fin = fin; v.f23 = f23; v.fl = fl; v.a = a; v.b = b;
        v.ef = ef; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4; v.e5 = e5; v.el = el;
        return v;
    endfunction

    // Upper byte-input bits and the pass-through inputs get junk; the stage must ignore them.
    task automatic apply(input logic ff, input logic fin, input logic f23, input logic [1:0] fl,
                         input logic [8:0] a, input logic [8:0] b);
        @(negedge clk);
        flag_first = ff;
        final_flag = fin;
        final_2_3  = f23;
        aflag      = fl;
        bs1        = {7'($urandom), a};
        bs2        = {7'($urandom), b};
        rng        = 16'($urandom);
        low        = 24'($urandom);
        cnt        = 5'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flag_first = 0; final_flag = 0; final_2_3 = 0; aflag = 0; bs1 = 0; bs2 = 0;
    endtask

    task automatic check_vec(input vec_t v, input string name);
        apply(v.ff, v.fin, v.f23, v.fl, v.a, v.b);
        checks++;
        if ({oflag, b1, b2, b3, b4, b5, olast} !== {v.ef, v.e1, v.e2, v.e3, v.e4, v.e5, v.el}) begin
            errors++;
            $display("FAIL %s: got flag=%0d bytes=%02h %02h %02h %02h %02h last=%0b, expected flag=%0d bytes=%02h %02h %02h %02h %02h last=%0b",
                     name, oflag, b1, b2, b3, b4, b5, olast,
                     v.ef, v.e1, v.e2, v.e3, v.e4, v.e5, v.el);
        end
    endtask

    // Reference: held bytes are a queue; a carry ripples through it as plain +1 arithmetic.
    logic [7:0] held_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         pend;

    task automatic model_byte(input logic [8:0] x);
        if (held_q.size() == 0) begin
            held_q.push_back(x[7:0]);
        end else if (!x[8] && (x[7:0] == 8'hFF)) begin
            assert (held_q.size() < 16) else $error("pending 0xFF run exceeds 15");
            held_q.push_back(8'hFF);
        end else begin
            if (x[8]) begin
                for (int i = held_q.size() - 1; i >= 0; i--) begin
                    held_q[i] = held_q[i] + 8'd1;
                    if (held_q[i] != 8'h00) break;
                end
            end
            foreach (held_q[i]) exp_q.push_back(held_q[i]);
            held_q.delete();
            held_q.push_back(x[7:0]);
        end
    endtask

    function automatic logic [8:0] gen_byte();
        logic [8:0] x;
        x[8]   = ($urandom_range(0, 3) == 0);
        x[7:0] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        if (!x[8] && (x[7:0] == 8'hFF) && (held_q.size() >= 16)) x[7:0] = 8'h00;
        return x;
    endfunction

    // Expands the DUT's compact group back into a byte list and compares with the model.
    task automatic check_group(input int cyc, input logic el);
        bit    ok;
        string gs, es;
        got_q.delete();
        ok = 1;
        case (oflag)
            3'd0: if ({b1, b2, b3, b4, b5} != 40'h0) ok = 0;
            3'd1, 3'd2, 3'd3, 3'd4: begin
                got_q.push_back(b1);
                if (oflag >= 3'd2) got_q.push_back(b2);
                if (oflag >= 3'd3) got_q.push_back(b3);
                if (oflag >= 3'd4) got_q.push_back(b4);
            end
            default: begin
                got_q.push_back(b1);
                if (b3 == 8'd0 || b3 > 8'd15) ok = 0;
                for (int k = 0; k < int'(b3); k++) got_q.push_back(b2);
                if (oflag >= 3'd6) got_q.push_back(b4);
                if (oflag == 3'd7) got_q.push_back(b5);
            end
        endcase
        if (got_q.size() != exp_q.size()) ok = 0;
        else foreach (exp_q[i]) if (got_q[i] != exp_q[i]) ok = 0;
        if (olast != el) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            gs = ""; es = "";
            foreach (got_q[i]) gs = {gs, $sformatf(" %02h", got_q[i])};
            foreach (exp_q[i]) es = {es, $sformatf(" %02h", exp_q[i])};
            $display("FAIL grp cyc %0d: got flag=%0d last=%0b bytes=[%s ], expected last=%0b bytes=[%s ]",
                     cyc, oflag, olast, gs, el, es);
        end
    endtask

    initial begin
        logic       ff, fin, f23, el;
        logic [1:0] fl;
        logic [8:0] a, b;

        rst_n = 0; rng = 0; low = 0; cnt = 0;
        idle_inputs();
        #12;
        checks++;
        if ({oflag, b1, b2, b3, b4, b5, olast} !== 44'h0) begin
            errors++;
            $display("FAIL reset: got flag=%0d b1=%02h last=%0b, expected all zero", oflag, b1, olast);
        end
        @(negedge clk);
        rst_n = 1;

        //             ff fin f23 fl  a       b       ef  e1     e2     e3     e4     e5     el
        vecs.push_back(mk(1, 0, 0, 0, 9'h000, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h012, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h034, 9'h000, 1, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h0FF, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h0FF, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h105, 9'h000, 5, 8'h35, 8'h00, 8'h02, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2, 9'h010, 9'h020, 2, 8'h05, 8'h10, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2, 9'h1FF, 9'h007, 2, 8'h21, 8'hFF, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h0FF, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 2, 9'h030, 9'h040, 6, 8'h07, 8'hFF, 8'h01, 8'h30, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 2, 9'h050, 9'h0FF, 3, 8'h40, 8'h50, 8'hFF, 8'h00, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 3, 9'h011, 9'h022, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h0AB, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 1, 1, 1, 9'h0FF, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h000, 5, 8'hAB, 8'hFF, 8'h01, 8'h00, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 0, 9'h000, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h133, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 0, 9'h000, 9'h000, 1, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 1));
        vecs.push_back(mk(0, 1, 0, 0, 9'h000, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 1, 9'h0FF, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h102, 9'h000, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 1, 9'h077, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h088, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 0, 9'h000, 9'h000, 1, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 1, 9'h010, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h0FF, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h0FF, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 2, 9'h101, 9'h0FF, 7, 8'h11, 8'h00, 8'h02, 8'h01, 8'hFF, 1));
        vecs.push_back(mk(0, 0, 0, 2, 9'h0FF, 9'h0FF, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9'h080, 9'h000, 5, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 0, 9'h000, 9'h000, 1, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 1));

        foreach (vecs[i]) check_vec(vecs[i], $sformatf("vec%0d", i));

        // Longest legal pending run: 15 carry-free 0xFF bytes behind 0x01.
        check_vec(mk(0, 0, 0, 1, 9'h001, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0), "run15_init");
        for (int k = 0; k < 15; k++)
            check_vec(mk(0, 0, 0, 1, 9'h0FF, 9'h000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0),
                      $sformatf("run15_hold%0d", k));
        check_vec(mk(0, 0, 0, 1, 9'h002, 9'h000, 5, 8'h01, 8'hFF, 8'h0F, 8'h00, 8'h00, 0), "run15_rel");
        check_vec(mk(0, 1, 0, 0, 9'h000, 9'h000, 1, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 1), "run15_flush");

        held_q.delete();
        pend = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            exp_q.delete();
            ff  = ($urandom_range(0, 49) == 0);
            fin = !pend && ($urandom_range(0, 19) == 0);
            f23 = fin && ($urandom_range(0, 1) == 1);
            fl  = pend ? 2'd0 : 2'($urandom_range(0, 3));
            el  = 0;
            a   = gen_byte();
            if (ff) begin
                b = gen_byte();
                held_q.delete();
                pend = 0;
            end else begin
                if (fl == 2'd1 || fl == 2'd2) model_byte(a);
                b = gen_byte();
                if (fl == 2'd2) model_byte(b);
                if ((fin && !f23) || pend) begin
                    foreach (held_q[i]) exp_q.push_back(held_q[i]);
                    held_q.delete();
                    el = 1;
                end
                pend = fin && f23 && !pend;
            end
            apply(ff, fin, f23, fl, a, b);
            check_group(cyc, el);

            if (cyc == 300) begin
                @(negedge clk);
                idle_inputs();
                rst_n = 0;
                #1;
                checks++;
                if ({oflag, b1, b2, b3, b4, b5, olast} !== 44'h0) begin
                    errors++;
                    $display("FAIL async_reset: got flag=%0d b1=%02h last=%0b, expected all zero",
                             oflag, b1, olast);
                end
                @(negedge clk);
                rst_n = 1;
                held_q.delete();
                pend = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
